alu_mul_sequencer: RTL and testbench

Iterative 32×32 shift-add multiplier that drives the datapath ALU as its initiator. It owns the ALU's operand/opcode inputs and consumes its result and carry, one ALU operation per cycle. It accepts operands over a valid/ready handshake and returns the low 32 bits of the product plus an overflow flag. It sits beside the ALU in the execute stage and time-shares the ALU port while the core stalls.

---
 rtl/alu_mul_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Iterative 32x32 shift-add multiplier that sequences an external ALU one op per cycle.
// Optional signed support is compiled in with `define MUL_SIGNED_EN.
module alu_mul_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        is_signed,
  output logic        out_valid,
  output logic [31:0] product,
  output logic        ovf,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_carry
);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_NEG = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_SHL = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ADD, S_SHL, S_SHR, S_NEG_P, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] product_q, product_d;
  logic        ovf_q, ovf_d;
  logic        sgn;

`ifdef MUL_SIGNED_EN
  logic        neg_p_q, neg_p_d;
  assign sgn = is_signed;
`else
  logic        unused_is_signed;
  assign unused_is_signed = is_signed;
  assign sgn = 1'b0;
`endif

  // Next multiply step for a multiplier value: finish, add a partial product, or just shift.
  function automatic state_e step_for(input logic [31:0] m);
    if (m == '0)
      return S_DONE;
    else if (m[0])
      return S_ADD;
    else
      return S_SHL;
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign product   = product_q;
  assign ovf       = ovf_q;

  // ALU drive depends only on registered state so the external ALU never loops back into it.
  always_comb begin
    alu_op    = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_shamt = '0;
    case (state_q)
      S_ADD: begin
        alu_op = OP_ADD;
        alu_a  = acc_q;
        alu_b  = mcand_q;
      end
      S_SHL: begin
        alu_op    = OP_SHL;
        alu_a     = mcand_q;
        alu_shamt = 5'd1;
      end
      S_SHR: begin
        alu_op    = OP_SHR;
        alu_a     = mplier_q;
        alu_shamt = 5'd1;
      end
`ifdef MUL_SIGNED_EN
      S_NEG_A: begin
        alu_op = OP_NEG;
        alu_b  = mcand_q;
      end
      S_NEG_B: begin
        alu_op = OP_NEG;
        alu_b  = mplier_q;
      end
      S_NEG_P: begin
        alu_op = OP_NEG;
        alu_b  = acc_q;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    product_d = product_q;
`ifdef MUL_SIGNED_EN
    neg_p_d   = neg_p_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          ovf_d    = 1'b0;
`ifdef MUL_SIGNED_EN
          neg_p_d  = sgn & (op_a[31] ^ op_b[31]);
`endif
          if (sgn && op_a[31])
            state_d = S_NEG_A;
          else if (sgn && op_b[31])
            state_d = S_NEG_B;
          else
            state_d = step_for(op_b);
        end
      end
`ifdef MUL_SIGNED_EN
      S_NEG_A: begin
        mcand_d = alu_result;
        // a was negative, so b is negative exactly when the product sign stays positive
        if (!neg_p_q)
          state_d = S_NEG_B;
        else
          state_d = step_for(mplier_q);
      end
      S_NEG_B: begin
        mplier_d = alu_result;
        state_d  = alu_result[0] ? S_ADD : S_SHL;
      end
      S_NEG_P: begin
        acc_d   = alu_result;
        state_d = S_DONE;
      end
`endif
      S_ADD: begin
        acc_d = alu_result;
        if (alu_carry)
          ovf_d = 1'b1;
        state_d = S_SHL;
      end
      S_SHL: begin
        mcand_d = alu_result;
        // a set bit leaving the top of mcand is lost to every later partial product
        if (mcand_q[31] && (mplier_q[31:1] != '0))
          ovf_d = 1'b1;
        state_d = S_SHR;
      end
      S_SHR: begin
        mplier_d = alu_result;
        if (alu_result == '0) begin
`ifdef MUL_SIGNED_EN
          state_d = neg_p_q ? S_NEG_P : S_DONE;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = alu_result[0] ? S_ADD : S_SHL;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE)
      product_d = acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      product_q <= '0;
`ifdef MUL_SIGNED_EN
      neg_p_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      product_q <= product_d;
`ifdef MUL_SIGNED_EN
      neg_p_q   <= neg_p_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a behavioural ALU attached to its initiator port.
module tb_alu_mul_sequencer;

`ifdef MUL_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        is_signed;
  logic        out_valid;
  logic [31:0] product;
  logic        ovf;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_carry;

  typedef struct {
    logic [31:0] prod;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;
  logic ov_prev = 1'b0;

  alu_mul_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .is_signed(is_signed),
    .out_valid(out_valid), .product(product), .ovf(ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_op)
      4'b0001: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      4'b1011: alu_result = alu_a << alu_shamt;
      4'b1001: alu_result = alu_a >> alu_shamt;
      4'b0101: alu_result = ~alu_b + 32'd1;
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input int acc_cyc);
    exp_t        r;
    logic        sg;
    logic [31:0] ma, mb;
    logic [63:0] full;
    int          n, msb;
    sg   = s & SIGNED_EN;
    ma   = (sg && a[31]) ? (~a + 32'd1) : a;
    mb   = (sg && b[31]) ? (~b + 32'd1) : b;
    full = {32'd0, ma} * {32'd0, mb};
    n    = 0;
    msb  = 0;
    if (sg && a[31]) n++;
    if (sg && b[31]) n++;
    if (mb != 0) begin
      for (int i = 0; i < 32; i++) if (mb[i]) msb = i;
      n += $countones(mb) + 2 * (msb + 1);
      if (sg && (a[31] ^ b[31])) n++;
    end
    r.prod = a * b;
    r.ovf  = |full[63:32];
    r.due  = acc_cyc + n;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check_eq("ov_pulse", {63'd0, ov_prev}, 64'd0);
      if (sb.size() == 0) begin
        check_eq("spurious_ov", {63'd0, out_valid}, 64'd0);
      end else begin
        check_eq("product", {32'd0, product}, {32'd0, sb[0].prod});
        check_eq("ovf", {63'd0, ovf}, {63'd0, sb[0].ovf});
        check_eq("latency", 64'(cyc), 64'(sb[0].due));
        sb.delete(0);
      end
    end
    ov_prev <= rst_n && out_valid;
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check_eq("ready_timeout", {63'd0, in_ready}, 64'd1);
      return;
    end
    in_valid  = 1'b1;
    op_a      = a;
    op_b      = b;
    is_signed = s;
    @(posedge clk);
    #1;
    sb.push_back(model(a, b, s, cyc));
    for (int i = 0; i < hold; i++) begin
      op_a      = $urandom;
      op_b      = $urandom;
      is_signed = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("busy_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check_eq("drain", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] pat [3];
    pat[0] = 4'b0001;
    pat[1] = 4'b1011;
    pat[2] = 4'b1001;
    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; is_signed = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_ov", {63'd0, out_valid}, 64'd0);
    check_eq("rst_product", {32'd0, product}, 64'd0);
    check_eq("rst_ovf", {63'd0, ovf}, 64'd0);
    check_eq("rst_aluop", {60'd0, alu_op}, 64'd0);
    rst_n = 1'b1;

    issue(32'd6, 32'd7, 1'b0, 0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_eq("aluop_seq", {60'd0, alu_op}, {60'd0, pat[i % 3]});
    end
    drain();

    issue(32'h12345678, 32'h0, 1'b0, 0);
    issue(32'h00010000, 32'h00010000, 1'b0, 0);
    issue(32'hFFFFFFFF, 32'd3, 1'b0, 0);
    issue(32'hFFFFFFFA, 32'd7, 1'b1, 0);
    issue(32'hFFFFFFFA, 32'd7, 1'b0, 0);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
    issue(32'd1, 32'hFFFFFFFF, 1'b0, 0);
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 0);
    issue(32'd5, 32'hFFFFFFFD, 1'b1, 0);
    issue(32'hFFFFFFF0, 32'h0, 1'b1, 0);
    for (int i = 0; i < 8; i++)
      issue($urandom, $urandom >> $urandom_range(8, 31), 1'($urandom_range(0, 1)), 0);
    drain();

    issue(32'd6, 32'd7, 1'b0, 5);
    drain();

    issue(32'd6, 32'd7, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_shl", {60'd0, alu_op}, 64'hB);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", {63'd0, in_ready}, 64'd1);
    check_eq("mid_rst_ov", {63'd0, out_valid}, 64'd0);
    check_eq("mid_rst_product", {32'd0, product}, 64'd0);
    check_eq("mid_rst_ovf", {63'd0, ovf}, 64'd0);
    check_eq("mid_rst_aluop", {60'd0, alu_op}, 64'd0);
    check_eq("mid_rst_alua", {32'd0, alu_a}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("post_rst_ready", {63'd0, in_ready}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
